load_queue: RTL and testbench

//  Multi-entry, in-order successor of the single-slot load buffer: holds up to DEPTH address-resolved

---
 rtl/load_queue_if.sv | 35 +++
 rtl/load_queue.sv | 102 ++++++++++
 tb/tb_load_queue.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/load_queue_if.sv
// Bundle of load-queue signals shared with ACU, ROB and MEM.
// master = surrounding pipeline, slave = the queue itself.
interface load_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              alloc_enable;
  logic [ADDR_W-1:0] alloc_address;
  logic [TAG_W-1:0]  alloc_rob_tag;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic [TAG_W-1:0]  rob_head;
  logic              store_pending;
  logic [TAG_W-1:0]  oldest_store_tag;
  logic              mem_busy;
  logic              read_mem;
  logic [ADDR_W-1:0] load_address;
  logic [TAG_W-1:0]  load_rob_tag;

  modport master (
    output flush, alloc_enable, alloc_address, alloc_rob_tag,
    output rob_head, store_pending, oldest_store_tag, mem_busy,
    input  full, count, read_mem, load_address, load_rob_tag
  );

  modport slave (
    input  flush, alloc_enable, alloc_address, alloc_rob_tag,
    input  rob_head, store_pending, oldest_store_tag, mem_busy,
    output full, count, read_mem, load_address, load_rob_tag
  );
endinterface

// File: rtl/load_queue.sv
// In-order load queue: buffers address-resolved loads and issues the oldest
// to memory once no older store is pending in the ROB (ROB-relative age).
module load_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
  input logic         clock,
  input logic         reset,
  load_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DEPTH-1:0]  valid_vec, ready_vec;
  logic [ADDR_W-1:0] addr_arr [DEPTH];
  logic [TAG_W-1:0]  tag_arr  [DEPTH];

  logic              full_int, do_alloc, do_issue, head_valid, store_safe;
  logic [TAG_W-1:0]  head_tag, age_head, age_store;

  assign full_int   = (count_reg == CNT_W'(DEPTH));
  assign do_alloc   = q.alloc_enable && !full_int && !q.flush;
  assign head_valid = valid_vec[head_reg];
  assign head_tag   = tag_arr[head_reg];

  // Ages wrap modulo 2^TAG_W, so tag wrap-around needs no special case.
  assign age_head   = head_tag - q.rob_head;
  assign age_store  = q.oldest_store_tag - q.rob_head;
  assign store_safe = !q.store_pending || (age_head < age_store);
  assign do_issue   = head_valid && ready_vec[head_reg] && store_safe
                      && !q.mem_busy && !q.flush;

  assign q.full         = full_int;
  assign q.count        = count_reg;
  assign q.read_mem     = do_issue;
  assign q.load_address = head_valid ? addr_arr[head_reg] : '0;
  assign q.load_rob_tag = head_valid ? head_tag : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (q.flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_alloc) tail_reg <= tail_reg + PTR_W'(1);
      if (do_issue) head_reg <= head_reg + PTR_W'(1);
      case ({do_alloc, do_issue})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic              valid_reg, ready_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic              hit_alloc, hit_issue;

      assign hit_alloc = do_alloc && (tail_reg == PTR_W'(gi));
      assign hit_issue = do_issue && (head_reg == PTR_W'(gi));

      // ready lags valid by one edge so the ROB store status can settle.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
          addr_reg  <= '0;
          tag_reg   <= '0;
        end else if (q.flush) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
        end else if (hit_alloc) begin
          valid_reg <= 1'b1;
          ready_reg <= 1'b0;
          addr_reg  <= q.alloc_address;
          tag_reg   <= q.alloc_rob_tag;
        end else if (hit_issue) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
        end else if (valid_reg) begin
          ready_reg <= 1'b1;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign ready_vec[gi] = ready_reg;
      assign addr_arr[gi]  = addr_reg;
      assign tag_arr[gi]   = tag_reg;
    end
  endgenerate
endmodule

// File: tb/tb_load_queue.sv
// Directed bench for load_queue: reset, fill, latency, store age, full+issue,
// flush, and asynchronous reset mid-stream.
module tb_load_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  load_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) q ();

  load_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .q     (q.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic alloc(input logic en, input logic [31:0] a, input logic [4:0] t);
    q.alloc_enable  = en;
    q.alloc_address = a;
    q.alloc_rob_tag = t;
  endtask

  initial begin
    q.flush = 1'b0;
    alloc(1'b0, 32'h0, 5'd0);
    q.rob_head = 5'd0;
    q.store_pending = 1'b0;
    q.oldest_store_tag = 5'd0;
    q.mem_busy = 1'b0;

    // Reset state
    tick();
    check("rst_count", 32'(q.count), 32'd0);
    check("rst_full", 32'(q.full), 32'd0);
    check("rst_read_mem", 32'(q.read_mem), 32'd0);
    check("rst_addr", q.load_address, 32'h0);
    check("rst_tag", 32'(q.load_rob_tag), 32'd0);
    reset = 1'b0;

    // Order/latency: alloc at edge N, issue only after edge N+1
    alloc(1'b1, 32'h100, 5'd3);
    #1 check("lat_no_bypass", 32'(q.read_mem), 32'd0);
    tick();
    alloc(1'b0, 32'h0, 5'd0);
    #1;
    check("lat_cnt_N", 32'(q.count), 32'd1);
    check("lat_rd_N", 32'(q.read_mem), 32'd0);
    check("lat_tag_N", 32'(q.load_rob_tag), 32'd3);
    tick();
    check("lat_rd_N1", 32'(q.read_mem), 32'd1);
    check("lat_tag_N1", 32'(q.load_rob_tag), 32'd3);
    check("lat_addr_N1", q.load_address, 32'h100);
    tick();
    check("lat_cnt_end", 32'(q.count), 32'd0);
    check("lat_rd_end", 32'(q.read_mem), 32'd0);
    check("lat_addr_end", q.load_address, 32'h0);

    // Store age with tag wrap: rob_head=30, head tag 1 (age 3)
    q.rob_head = 5'd30;
    q.store_pending = 1'b1;
    q.oldest_store_tag = 5'd31;
    alloc(1'b1, 32'h200, 5'd1);
    tick();
    alloc(1'b0, 32'h0, 5'd0);
    tick();
    check("age_blocked", 32'(q.read_mem), 32'd0);
    check("age_cnt", 32'(q.count), 32'd1);
    q.oldest_store_tag = 5'd2;
    #1 check("age_safe", 32'(q.read_mem), 32'd1);
    check("age_addr", q.load_address, 32'h200);
    tick();
    check("age_cnt_end", 32'(q.count), 32'd0);
    q.store_pending = 1'b0;
    q.rob_head = 5'd0;

    // Fill: five allocs with mem busy, fifth ignored
    q.mem_busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      alloc(1'b1, 32'h10 * k, 5'(k));
      tick();
      check("fill_cnt", 32'(q.count), (k < 4) ? k : 4);
      check("fill_full", 32'(q.full), (k >= 4) ? 1 : 0);
    end
    alloc(1'b0, 32'h0, 5'd0);
    #1 check("fill_head_tag", 32'(q.load_rob_tag), 32'd1);
    check("fill_head_addr", q.load_address, 32'h10);

    // Full + simultaneous alloc: issue happens, alloc ignored
    q.mem_busy = 1'b0;
    alloc(1'b1, 32'h900, 5'd9);
    #1 check("fs_rd", 32'(q.read_mem), 32'd1);
    check("fs_full", 32'(q.full), 32'd1);
    tick();
    alloc(1'b0, 32'h0, 5'd0);
    #1 check("fs_cnt", 32'(q.count), 32'd3);
    check("fs_full_after", 32'(q.full), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      check("fs_drain_rd", 32'(q.read_mem), 32'd1);
      check("fs_drain_tag", 32'(q.load_rob_tag), k);
      tick();
    end
    check("fs_empty_cnt", 32'(q.count), 32'd0);
    check("fs_empty_rd", 32'(q.read_mem), 32'd0);

    // Flush with same-cycle alloc
    q.mem_busy = 1'b1;
    alloc(1'b1, 32'h70, 5'd7);  tick();
    alloc(1'b1, 32'h80, 5'd8);  tick();
    alloc(1'b1, 32'hA0, 5'd10); tick();
    check("fl_cnt_pre", 32'(q.count), 32'd3);
    q.mem_busy = 1'b0;
    q.flush = 1'b1;
    alloc(1'b1, 32'hB0, 5'd11);
    #1 check("fl_rd_supp", 32'(q.read_mem), 32'd0);
    tick();
    q.flush = 1'b0;
    alloc(1'b0, 32'h0, 5'd0);
    #1 check("fl_cnt", 32'(q.count), 32'd0);
    check("fl_rd", 32'(q.read_mem), 32'd0);
    check("fl_tag", 32'(q.load_rob_tag), 32'd0);
    tick();
    check("fl_cnt_later", 32'(q.count), 32'd0);

    // Asynchronous reset mid-stream with 3 entries
    q.mem_busy = 1'b1;
    alloc(1'b1, 32'h30, 5'd4);  tick();
    alloc(1'b1, 32'h40, 5'd5);  tick();
    alloc(1'b1, 32'h50, 5'd6);  tick();
    alloc(1'b0, 32'h0, 5'd0);
    q.mem_busy = 1'b0;
    #1 check("ar_cnt_pre", 32'(q.count), 32'd3);
    check("ar_rd_pre", 32'(q.read_mem), 32'd1);
    reset = 1'b1;
    #1 check("ar_cnt", 32'(q.count), 32'd0);
    check("ar_full", 32'(q.full), 32'd0);
    check("ar_rd", 32'(q.read_mem), 32'd0);
    check("ar_addr", q.load_address, 32'h0);
    tick();
    reset = 1'b0;
    alloc(1'b1, 32'hC0, 5'd12);
    tick();
    alloc(1'b0, 32'h0, 5'd0);
    tick();
    check("ar_restart_rd", 32'(q.read_mem), 32'd1);
    check("ar_restart_tag", 32'(q.load_rob_tag), 32'd12);
    tick();
    check("ar_restart_cnt", 32'(q.count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
